// File: rtl/usb_rx_pkt_check.sv
// USB receive packet checker: PID decode/validation, CRC5/CRC16 residue check,
// token field capture and payload byte delivery with the trailing CRC16 stripped.
module usb_rx_pkt_check #(
  parameter int MAX_PAYLOAD = 1023,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             pkt_end,
  output logic [3:0]       pid_out,
  output logic             pid_valid,
  output logic [10:0]      tok_data,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic [1:0]       pkt_kind,
  output logic             pkt_done,
  output logic             pid_ok,
  output logic             crc_ok,
  output logic             len_ok
);

  typedef enum logic [2:0] {IDLE, PID, TOKEN, DATA, HSK, DRAIN} state_t;

  state_t      state;
  logic [6:0]  sh;        // bits of the byte being assembled, newest at [6]
  logic [2:0]  bph;       // bit position within the current byte
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [4:0]  tok_cnt;   // token body bits, saturating at 17
  logic [1:0]  held;      // completed bytes held in the delay line (0..2)
  logic [7:0]  h1, h2;    // h1 = previous byte, h2 = the one before it
  logic        ovf;
  logic        hsk_err;

  logic        acc;
  logic [7:0]  cur_byte;
  logic        pid_good;
  logic [1:0]  pid_cls;
  logic        c5_fb, c16_fb;
  logic [4:0]  crc5_nxt;
  logic [15:0] crc16_nxt;

  // Bit acceptance, completed-byte view, PID class and next CRC values
  always_comb begin
    acc       = bit_valid & ~pkt_end;
    cur_byte  = {bit_in, sh};
    pid_good  = (cur_byte[7:4] == ~cur_byte[3:0]);
    c5_fb     = crc5[4] ^ bit_in;
    c16_fb    = crc16[15] ^ bit_in;
    crc5_nxt  = {crc5[3:0], 1'b0} ^ (c5_fb ? 5'h05 : 5'h00);
    crc16_nxt = {crc16[14:0], 1'b0} ^ (c16_fb ? 16'h8005 : 16'h0000);
    case (cur_byte[3:0])
      4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0100: pid_cls = 2'd0;
      4'b0011, 4'b1011, 4'b0111, 4'b1111:          pid_cls = 2'd1;
      4'b0010, 4'b1010, 4'b1110, 4'b0110:          pid_cls = 2'd2;
      default:                                     pid_cls = 2'd3;
    endcase
  end

  // Packet FSM: start/abort, bit processing per state, and end-of-packet verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      bph        <= '0;
      crc5       <= '1;
      crc16      <= '1;
      tok_cnt    <= '0;
      held       <= '0;
      h1         <= '0;
      h2         <= '0;
      ovf        <= 1'b0;
      hsk_err    <= 1'b0;
      pid_out    <= '0;
      pid_valid  <= 1'b0;
      tok_data   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_count <= '0;
      pkt_kind   <= 2'd3;
      pkt_done   <= 1'b0;
      pid_ok     <= 1'b0;
      crc_ok     <= 1'b0;
      len_ok     <= 1'b0;
    end else begin
      pid_valid  <= 1'b0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      if (pkt_start) begin
        // a new SYNC overrides whatever was in flight
        state      <= PID;
        sh         <= '0;
        bph        <= '0;
        crc5       <= '1;
        crc16      <= '1;
        tok_cnt    <= '0;
        held       <= '0;
        h1         <= '0;
        h2         <= '0;
        ovf        <= 1'b0;
        hsk_err    <= 1'b0;
        tok_data   <= '0;
        byte_count <= '0;
        pkt_kind   <= 2'd3;
        pid_ok     <= 1'b0;
        crc_ok     <= 1'b0;
        len_ok     <= 1'b0;
      end else if (pkt_end && state != IDLE) begin
        pkt_done <= 1'b1;
        state    <= IDLE;
        case (state)
          PID: begin
            pid_ok   <= 1'b0;
            pkt_kind <= 2'd3;
            len_ok   <= 1'b0;
            crc_ok   <= 1'b0;
          end
          TOKEN: begin
            len_ok <= (tok_cnt == 5'd16);
            crc_ok <= (crc5 == 5'h0C);
          end
          DATA: begin
            len_ok <= (bph == 3'd0) && (held == 2'd2) && !ovf;
            crc_ok <= (crc16 == 16'h800D);
          end
          HSK: begin
            len_ok <= !hsk_err;
            crc_ok <= 1'b1;
          end
          default: begin
            len_ok <= 1'b0;
            crc_ok <= 1'b0;
          end
        endcase
      end else if (acc) begin
        // CRC covers only the body; PID bits never reach the engines
        if (state != IDLE && state != PID) begin
          crc5  <= crc5_nxt;
          crc16 <= crc16_nxt;
        end
        case (state)
          PID: begin
            sh  <= {bit_in, sh[6:1]};
            bph <= bph + 3'd1;
            if (bph == 3'd7) begin
              pid_ok <= pid_good;
              if (!pid_good) begin
                pkt_kind <= 2'd3;
                state    <= DRAIN;
              end else begin
                pid_out   <= cur_byte[3:0];
                pid_valid <= 1'b1;
                pkt_kind  <= pid_cls;
                case (pid_cls)
                  2'd0:    state <= TOKEN;
                  2'd1:    state <= DATA;
                  2'd2:    state <= HSK;
                  default: state <= DRAIN;
                endcase
              end
            end
          end
          TOKEN: begin
            if (tok_cnt < 5'd11) tok_data[tok_cnt[3:0]] <= bit_in;
            if (tok_cnt != 5'd17) tok_cnt <= tok_cnt + 5'd1;
          end
          DATA: begin
            sh  <= {bit_in, sh[6:1]};
            bph <= bph + 3'd1;
            if (bph == 3'd7) begin
              // the two newest bytes may be the CRC, so only the third-newest leaves
              if (held == 2'd2) begin
                if (byte_count == CNT_W'(MAX_PAYLOAD)) begin
                  ovf <= 1'b1;
                end else begin
                  data_out   <= h2;
                  data_valid <= 1'b1;
                  byte_count <= byte_count + 1'b1;
                end
              end else begin
                held <= held + 2'd1;
              end
              h2 <= h1;
              h1 <= cur_byte;
            end
          end
          HSK:     hsk_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_check.sv
// Bench for usb_rx_pkt_check: directed and random packets, reference model,
// scoreboard queues and a monitor; a second instance runs with MAX_PAYLOAD=4.
module tb_usb_rx_pkt_check;

  logic clk = 1'b0;
  logic rst_n, pkt_start, bit_in, bit_valid, pkt_end;
  always #5 clk = ~clk;

  logic [3:0]  po0, po1;
  logic        pv0, pv1, dv0, dv1, dn0, dn1;
  logic [10:0] tok0, tok1, bc0;
  logic [2:0]  bc1;
  logic [7:0]  do0, do1;
  logic [1:0]  kd0, kd1;
  logic        pok0, pok1, cok0, cok1, lok0, lok1;

  usb_rx_pkt_check dut0 (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .pkt_end(pkt_end), .pid_out(po0), .pid_valid(pv0),
    .tok_data(tok0), .data_out(do0), .data_valid(dv0), .byte_count(bc0),
    .pkt_kind(kd0), .pkt_done(dn0), .pid_ok(pok0), .crc_ok(cok0), .len_ok(lok0));

  usb_rx_pkt_check #(.MAX_PAYLOAD(4), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .pkt_end(pkt_end), .pid_out(po1), .pid_valid(pv1),
    .tok_data(tok1), .data_out(do1), .data_valid(dv1), .byte_count(bc1),
    .pkt_kind(kd1), .pkt_done(dn1), .pid_ok(pok1), .crc_ok(cok1), .len_ok(lok1));

  typedef struct packed {
    logic [1:0]  kind;
    logic        pid_ok, crc_ok, len_ok;
    logic [10:0] bc;
    logic [10:0] tok;
  } done_t;

  int compared = 0, mismatched = 0;
  bit stream[$];
  logic [7:0] exp_d0[$], exp_d1[$];
  done_t      exp_k0[$], exp_k1[$];
  logic [3:0] exp_p0[$], exp_p1[$];
  logic [3:0] tokp[5] = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h4};
  logic [3:0] datp[4] = '{4'h3, 4'hB, 4'h7, 4'hF};
  logic [3:0] hskp[4] = '{4'h2, 4'hA, 4'hE, 4'h6};
  logic [3:0] resp[3] = '{4'hC, 4'h8, 4'h0};

  task automatic chk(string nm, int inst, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, inst, act, exp);
    end
  endtask

  // Transmit-side CRC register over stream[start +: len], initial value all ones
  function automatic logic [15:0] crc_reg(int start, int len, int w);
    logic [15:0] r, poly, mask;
    logic fb;
    r    = (w == 5) ? 16'h001F : 16'hFFFF;
    mask = r;
    poly = (w == 5) ? 16'h0005 : 16'h8005;
    for (int i = 0; i < len; i++) begin
      fb = r[w-1] ^ stream[start+i];
      r  = ((r << 1) & mask) ^ (fb ? poly : 16'h0000);
    end
    return r;
  endfunction

  // A body is good when its last w bits are the complemented CRC of the rest, MSB first
  function automatic bit crc_good(int start, int nb, int w);
    logic [15:0] r;
    if (nb < w) return 1'b0;
    r = crc_reg(start, nb - w, w);
    for (int k = 0; k < w; k++)
      if (stream[start+nb-w+k] != ~r[w-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic append_crc(int w);
    logic [15:0] r;
    r = crc_reg(8, stream.size() - 8, w);
    for (int k = 0; k < w; k++) stream.push_back(~r[w-1-k]);
  endtask

  task automatic add_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) stream.push_back(b[i]);
  endtask

  task automatic add_bits(int n);
    for (int i = 0; i < n; i++) stream.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic flip_body();
    int idx;
    idx = $urandom_range(8, stream.size() - 1);
    stream[idx] = ~stream[idx];
  endtask

  // Reference model: expected pid, payload bytes and end-of-packet verdict per instance
  task automatic model_pkt(bit ended);
    done_t d, di;
    logic [7:0] pb;
    int n, nb, full, em, cap, mx;
    n = stream.size(); nb = 0; d = '0; d.kind = 2'd3;
    if (n >= 8) begin
      for (int i = 0; i < 8; i++) pb[i] = stream[i];
      if (pb[7:4] == ~pb[3:0]) begin
        exp_p0.push_back(pb[3:0]);
        exp_p1.push_back(pb[3:0]);
        d.pid_ok = 1'b1;
        nb = n - 8;
        if (pb[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD, 4'h4}) begin
          d.kind = 2'd0;
          for (int i = 0; i < nb && i < 11; i++) d.tok[i] = stream[8+i];
          d.len_ok = (nb == 16);
          d.crc_ok = crc_good(8, nb, 5);
        end else if (pb[3:0] inside {4'h3, 4'hB, 4'h7, 4'hF}) begin
          d.kind = 2'd1;
          d.crc_ok = crc_good(8, nb, 16);
        end else if (pb[3:0] inside {4'h2, 4'hA, 4'hE, 4'h6}) begin
          d.kind = 2'd2;
          d.len_ok = (nb == 0);
          d.crc_ok = 1'b1;
        end
      end
    end
    for (int inst = 0; inst < 2; inst++) begin
      di = d;
      if (d.kind == 2'd1 && d.pid_ok) begin
        mx   = (inst == 0) ? 1023 : 4;
        full = nb / 8;
        em   = (full > 2) ? full - 2 : 0;
        cap  = (em > mx) ? mx : em;
        for (int j = 0; j < cap; j++) begin
          for (int b = 0; b < 8; b++) pb[b] = stream[8 + 8*j + b];
          if (inst == 0) exp_d0.push_back(pb); else exp_d1.push_back(pb);
        end
        di.bc = 11'(cap);
        di.len_ok = (nb % 8 == 0) && (nb >= 16) && (em <= mx);
      end
      if (ended) begin
        if (inst == 0) exp_k0.push_back(di); else exp_k1.push_back(di);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sends the stream with random gaps; optionally closes it with pkt_end
  task automatic drive(bit do_end, bit coinc);
    model_pkt(do_end);
    pkt_start = 1'b1; bit_valid = 1'b0; tick();
    pkt_start = 1'b0;
    foreach (stream[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        bit_valid = 1'b0; bit_in = 1'($urandom_range(0, 1)); tick();
      end
      bit_valid = 1'b1; bit_in = stream[i]; tick();
    end
    bit_valid = 1'b0;
    if (do_end) begin
      pkt_end = 1'b1; bit_valid = coinc; bit_in = 1'($urandom_range(0, 1)); tick();
      pkt_end = 1'b0; bit_valid = 1'b0; tick(); tick();
      // idle noise must not produce anything
      repeat ($urandom_range(0, 3)) begin
        bit_valid = 1'($urandom_range(0, 1)); bit_in = 1'($urandom_range(0, 1));
        pkt_end = ($urandom_range(0, 4) == 0); tick();
      end
      bit_valid = 1'b0; pkt_end = 1'b0;
    end
  endtask

  task automatic mon(int i, logic pv, logic [3:0] po, logic dv, logic [7:0] dout, logic dn, done_t act);
    if (pv) begin
      if ((i == 0 ? exp_p0.size() : exp_p1.size()) == 0) chk("pid_valid_unexpected", i, pv, 0);
      else chk("pid_out", i, po, (i == 0) ? exp_p0.pop_front() : exp_p1.pop_front());
    end
    if (dv) begin
      if ((i == 0 ? exp_d0.size() : exp_d1.size()) == 0) chk("data_valid_unexpected", i, dv, 0);
      else chk("data_out", i, dout, (i == 0) ? exp_d0.pop_front() : exp_d1.pop_front());
    end
    if (dn) begin
      if ((i == 0 ? exp_k0.size() : exp_k1.size()) == 0) chk("pkt_done_unexpected", i, dn, 0);
      else chk("pkt_done_status", i, act, (i == 0) ? exp_k0.pop_front() : exp_k1.pop_front());
    end
  endtask

  // Monitor: compares each DUT output event against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, pv0, po0, dv0, do0, dn0, done_t'({kd0, pok0, cok0, lok0, bc0, tok0}));
      mon(1, pv1, po1, dv1, do1, dn1, done_t'({kd1, pok1, cok1, lok1, {8'd0, bc1}, tok1}));
    end
  end

  task automatic check_reset(string nm);
    chk(nm, 0, {po0, pv0, tok0, do0, dv0, bc0, kd0, dn0, pok0, cok0, lok0},
        {4'd0, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, 2'd3, 1'b0, 3'b000});
    chk(nm, 1, {po1, pv1, tok1, do1, dv1, bc1, kd1, dn1, pok1, cok1, lok1},
        {4'd0, 1'b0, 11'd0, 8'd0, 1'b0, 3'd0, 2'd3, 1'b0, 3'b000});
  endtask

  logic [7:0] setup_pkt[11] = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};

  initial begin
    bit do_end;
    int t;
    logic [3:0] nib;
    rst_n = 1'b0; pkt_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; pkt_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset_state");
    rst_n = 1'b1; tick();

    // clean SETUP token
    stream.delete(); add_byte(8'h2D); add_byte(8'h00); add_byte(8'h10); drive(1, 0);
    // SETUP data stage, then the same with one payload bit flipped
    stream.delete(); foreach (setup_pkt[i]) add_byte(setup_pkt[i]); drive(1, 0);
    stream.delete(); foreach (setup_pkt[i]) add_byte(setup_pkt[i]);
    stream[8+8+3] = ~stream[8+8+3]; drive(1, 0);
    // zero-length DATA1
    stream.delete(); add_byte(8'h4B); add_byte(8'h00); add_byte(8'h00); drive(1, 0);
    // ACK, ACK with trailing bits, ACK with a bit coincident with pkt_end
    stream.delete(); add_byte(8'hD2); drive(1, 0);
    stream.delete(); add_byte(8'hD2); add_bits(3); drive(1, 0);
    stream.delete(); add_byte(8'hD2); drive(1, 1);
    // PID complement error followed by bits to drain
    stream.delete(); add_byte(8'h2E); add_bits(13); drive(1, 0);
    // token cut after 12 body bits
    stream.delete(); add_byte(8'h2D); add_byte(8'h00); add_byte(8'h10);
    repeat (4) void'(stream.pop_back()); drive(1, 0);
    // 6-byte payload: overflows the MAX_PAYLOAD=4 instance only
    stream.delete(); add_byte(8'hC3); add_bits(48); append_crc(16); drive(1, 0);
    // abort mid-DATA via a new pkt_start
    stream.delete(); add_byte(8'hC3); add_bits(40); drive(0, 0);
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    chk("abort_byte_count", 0, bc0, 0);
    chk("abort_byte_count", 1, bc1, 0);
    stream.delete(); add_byte(8'h4B); add_bits(24); append_crc(16); drive(1, 0);
    // reset mid-packet clears outputs immediately
    stream.delete(); add_byte(8'hC3); add_bits(20); drive(0, 0);
    rst_n = 1'b0; #1 check_reset("midpkt_reset");
    tick(); tick(); rst_n = 1'b1; tick();

    // randomized packets
    for (int p = 0; p < 200; p++) begin
      stream.delete(); do_end = 1'b1;
      t = $urandom_range(0, 9);
      case (t)
        0, 1: begin
          nib = tokp[$urandom_range(0, 4)]; add_byte({~nib, nib}); add_bits(11); append_crc(5);
          if (t == 1) flip_body();
        end
        2: begin nib = tokp[$urandom_range(0, 4)]; add_byte({~nib, nib}); add_bits($urandom_range(5, 20)); end
        3, 4, 5: begin
          nib = datp[$urandom_range(0, 3)]; add_byte({~nib, nib});
          add_bits(8 * $urandom_range(0, 7)); append_crc(16);
          if (t == 4) flip_body();
          if (t == 5) add_bits($urandom_range(1, 7));
        end
        6: begin
          nib = hskp[$urandom_range(0, 3)]; add_byte({~nib, nib});
          if ($urandom_range(0, 1) == 1) add_bits($urandom_range(1, 5));
        end
        7: begin
          nib = 4'($urandom_range(0, 15));
          add_byte({~nib ^ 4'($urandom_range(1, 15)), nib}); add_bits($urandom_range(0, 20));
        end
        8: begin nib = resp[$urandom_range(0, 2)]; add_byte({~nib, nib}); add_bits($urandom_range(0, 20)); end
        default: add_bits($urandom_range(0, 7));
      endcase
      drive(do_end, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("leftover_pid", 0, exp_p0.size(), 0);
    chk("leftover_pid", 1, exp_p1.size(), 0);
    chk("leftover_data", 0, exp_d0.size(), 0);
    chk("leftover_data", 1, exp_d1.size(), 0);
    chk("leftover_done", 0, exp_k0.size(), 0);
    chk("leftover_done", 1, exp_k1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
